reset_sequencer: RTL and testbench

Central reset controller feeding the async-reset flop datapaths.
- Takes the board-level asynchronous active-low reset and synchronizes its deassertion.
- Releases NUM_STAGES downstream stage resets one at a time, spaced STAGE_DELAY cycles apart.
- Offers a four-phase req/ack soft-reset handshake that re-asserts all stages and re-runs the sequence.
- Sits at the top of each clock domain; every datapath register's async reset_n is driven by one stage_rst_n bit.

---
 rtl/rstseq_pkg.sv | 7 +
 rtl/reset_sync.sv | 14 +
 rtl/reset_sequencer.sv | 77 +++++++
 tb/tb_reset_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rstseq_pkg.sv
// rstseq_pkg: shared FSM state type and counter sizing for the reset sequencer
package rstseq_pkg;
  typedef enum logic [1:0] {ST_RELEASE, ST_DONE, ST_SOFT_HOLD} state_t;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/reset_sync.sv
// reset_sync: async-assert, sync-deassert reset synchronizer
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic rst_sync_n
);
  logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ff <= '0;
    else ff <= {ff[SYNC_STAGES-2:0], 1'b1};
  assign rst_sync_n = ff[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release with a four-phase soft-reset handshake
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SOFT_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  soft_rst_req,
  output logic                  soft_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  busy,
  output logic                  seq_done
);
  localparam int CW = cnt_width(STAGE_DELAY, SOFT_HOLD);
  localparam int IW = $clog2(NUM_STAGES + 1);
  localparam logic [CW-1:0] SD_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] SH_LAST = CW'(SOFT_HOLD - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);
  logic          rst_sync_n;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          soft_flag;
  reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .rst_sync_n (rst_sync_n)
  );
  // soft_flag remembers that the running release was soft-triggered, so only it raises ack
  always_ff @(posedge clk or negedge rst_sync_n)
    if (!rst_sync_n) begin
      state        <= ST_RELEASE;
      cnt          <= '0;
      idx          <= '0;
      soft_flag    <= 1'b0;
      stage_rst_n  <= '0;
      busy         <= 1'b1;
      seq_done     <= 1'b0;
      soft_rst_ack <= 1'b0;
    end else begin
      case (state)
        ST_RELEASE:
          if (cnt == SD_LAST) begin
            cnt         <= '0;
            idx         <= idx + IW'(1);
            stage_rst_n <= stage_rst_n | (NUM_STAGES'(1) << idx);
            if (idx == LAST_IDX) begin
              state        <= ST_DONE;
              seq_done     <= 1'b1;
              busy         <= 1'b0;
              soft_rst_ack <= soft_flag;
              soft_flag    <= 1'b0;
            end
          end else cnt <= cnt + CW'(1);
        ST_DONE:
          if (soft_rst_req && !soft_rst_ack) begin
            state       <= ST_SOFT_HOLD;
            stage_rst_n <= '0;
            seq_done    <= 1'b0;
            busy        <= 1'b1;
            soft_flag   <= 1'b1;
            cnt         <= '0;
            idx         <= '0;
          end else if (!soft_rst_req) soft_rst_ack <= 1'b0;
        ST_SOFT_HOLD:
          if (cnt == SH_LAST) begin
            state <= ST_RELEASE;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        default: state <= ST_RELEASE;
      endcase
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table-driven, scoreboard-checked bench for reset_sequencer
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       soft_rst_ack;
  logic [3:0] stage_rst_n;
  logic       busy;
  logic       seq_done;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  typedef struct {
    int at;
    logic [3:0] stg;
    logic b, d, a;
    string nm;
  } exp_t;
  typedef struct {
    int off;
    logic [3:0] stg;
    logic b, d;
  } vec_t;
  exp_t sb[$];
  vec_t prof[9];
  reset_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .soft_rst_req (soft_rst_req),
    .soft_rst_ack (soft_rst_ack),
    .stage_rst_n  (stage_rst_n),
    .busy         (busy),
    .seq_done     (seq_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input int at, input logic [3:0] s, input logic b, input logic d, input logic a);
    vectors++;
    if (at != cyc || {stage_rst_n, busy, seq_done, soft_rst_ack} !== {s, b, d, a}) begin
      miscompares++;
      $display("FAIL %s cyc=%0d(want %0d): got stg=%b busy=%b done=%b ack=%b, want stg=%b busy=%b done=%b ack=%b",
               nm, cyc, at, stage_rst_n, busy, seq_done, soft_rst_ack, s, b, d, a);
    end
  endtask
  always @(negedge clk)
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.nm, e.at, e.stg, e.b, e.d, e.a);
    end
  task automatic push_one(input string nm, input int at, input logic [3:0] s, input logic b, input logic d, input logic a);
    exp_t e;
    e.at = at; e.stg = s; e.b = b; e.d = d; e.a = a; e.nm = nm;
    sb.push_back(e);
  endtask
  task automatic push_profile(input string nm, input int base, input logic ackf, input int maxoff);
    foreach (prof[i])
      if (prof[i].off <= maxoff)
        push_one(nm, base + prof[i].off, prof[i].stg, prof[i].b, prof[i].d, prof[i].d ? ackf : 1'b0);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations still pending, want 0", sb.size());
      sb.delete();
    end
    #2;
  endtask
  int s, e0, t;
  initial begin
    prof[0] = '{0,  4'b0000, 1'b1, 1'b0};
    prof[1] = '{7,  4'b0000, 1'b1, 1'b0};
    prof[2] = '{8,  4'b0001, 1'b1, 1'b0};
    prof[3] = '{15, 4'b0001, 1'b1, 1'b0};
    prof[4] = '{16, 4'b0011, 1'b1, 1'b0};
    prof[5] = '{23, 4'b0011, 1'b1, 1'b0};
    prof[6] = '{24, 4'b0111, 1'b1, 1'b0};
    prof[7] = '{31, 4'b0111, 1'b1, 1'b0};
    prof[8] = '{32, 4'b1111, 1'b0, 1'b1};
    #1 reset_n = 1'b0;
    step(5);
    check("reset_state", cyc, 4'b0000, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    s = cyc + 2;
    push_profile("poweron", s, 1'b0, 99);
    drain();
    soft_rst_req = 1'b1;
    e0 = cyc + 1;
    push_one("soft_e0", e0, 4'b0000, 1'b1, 1'b0, 1'b0);
    push_profile("soft", e0 + 4, 1'b1, 99);
    drain();
    t = cyc;
    for (int k = 10; k <= 50; k += 10) push_one("held_req", t + k, 4'b1111, 1'b0, 1'b1, 1'b1);
    drain();
    soft_rst_req = 1'b0;
    push_one("ack_drop", cyc + 1, 4'b1111, 1'b0, 1'b1, 1'b0);
    drain();
    soft_rst_req = 1'b1;
    e0 = cyc + 1;
    push_one("retrig_e0", e0, 4'b0000, 1'b1, 1'b0, 1'b0);
    push_profile("retrig", e0 + 4, 1'b1, 99);
    drain();
    soft_rst_req = 1'b0;
    push_one("ack_drop2", cyc + 1, 4'b1111, 1'b0, 1'b1, 1'b0);
    drain();
    reset_n = 1'b0;
    #1 check("async_rst", cyc, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(3);
    reset_n = 1'b1;
    s = cyc + 2;
    push_profile("mid_pre", s, 1'b0, 16);
    step(s + 20 - cyc);
    reset_n = 1'b0;
    #1 check("mid_async", cyc, 4'b0000, 1'b1, 1'b0, 1'b0);
    sb.delete();
    step(3);
    reset_n = 1'b1;
    s = cyc + 2;
    push_profile("after_mid", s, 1'b0, 99);
    push_one("busy_req_e0", s + 33, 4'b0000, 1'b1, 1'b0, 1'b0);
    push_profile("busy_req", s + 37, 1'b1, 99);
    step(s + 10 - cyc);
    soft_rst_req = 1'b1;
    drain();
    soft_rst_req = 1'b0;
    push_one("ack_drop3", cyc + 1, 4'b1111, 1'b0, 1'b1, 1'b0);
    drain();
    step(3);
    t = cyc;
    reset_n = 1'b0;
    #1 check("glitch_async", cyc, 4'b0000, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b1;
    push_profile("glitch", t + 2, 1'b0, 99);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
